// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one single-cycle 32-bit ALU between two requesters. Requests are
//   chosen round-robin over valid/ready channels. The accepted operands are
//   held stable on the ALU pins for ALU_LAT cycles. The ALU result is then
//   registered and returned on the owner's response channel. Only one
//   operation is in flight at a time.
//
// Parameters:
//   ALU_LAT  cycles from operand issue to result capture (>= 1)
//   WIDTH    operand/result width (32 for this ALU)
//
// Ports:
//   clk, rst_n                        clock (rising edge), async active-low reset
//   req0_valid/ready/a/b/func         request channel, requester 0
//   req1_valid/ready/a/b/func         request channel, requester 1
//   rsp0_valid/ready/data/err         response channel, requester 0
//   rsp1_valid/ready/data/err         response channel, requester 1
//   alu_in1, alu_in2, alu_func        operands and function driven to the ALU
//   alu_out                           result returned by the ALU
//   busy                              high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int ALU_LAT = 1,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_func,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_func,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,

  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_func,
  input  logic [WIDTH-1:0] alu_out,

  output logic             busy
);

  // The counter only has to hold ALU_LAT-1.
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             last_grant_reg, last_grant_next;
  logic             owner_reg, owner_next;
  logic             err_reg, err_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [2:0]       func_reg, func_next;
  logic [WIDTH-1:0] result_reg, result_next;

  // ---------------------------------------------------------------------------
  // Round-robin selection. When both requesters are valid, the one that was
  // not served last wins. A lone valid requester always wins.
  // ---------------------------------------------------------------------------
  logic grant0, grant1;
  logic accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0]       sel_func;
  logic             sel_illegal;
  logic             owner_rsp_ready;

  assign grant0 = req0_valid && (!req1_valid || last_grant_reg);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_reg);

  // Gating the readies with rst_n keeps every output low while reset is held.
  assign req0_ready = rst_n && (state_reg == IDLE) && grant0;
  assign req1_ready = rst_n && (state_reg == IDLE) && grant1;

  assign accept = (state_reg == IDLE) && (grant0 || grant1);

  assign sel_a       = grant1 ? req1_a    : req0_a;
  assign sel_b       = grant1 ? req1_b    : req0_b;
  assign sel_func    = grant1 ? req1_func : req0_func;
  // Function codes 110 and 111 are illegal and return err.
  assign sel_illegal = (sel_func[2:1] == 2'b11);

  assign owner_rsp_ready = owner_reg ? rsp1_ready : rsp0_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    err_next        = err_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    func_next       = func_reg;
    result_next     = result_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          owner_next = grant1;
          if (sel_illegal) begin
            // Skip the ALU entirely. Its operand registers keep the previous
            // op, so the ALU pins do not move.
            err_next    = 1'b1;
            result_next = '0;
            state_next  = RESP;
          end else begin
            err_next   = 1'b0;
            a_next     = sel_a;
            b_next     = sel_b;
            func_next  = sel_func;
            cnt_next   = CW'(ALU_LAT - 1);
            state_next = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (cnt_reg == '0) begin
          result_next = alu_out;
          state_next  = RESP;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end

      RESP: begin
        // Only the owner's ready can complete the response.
        if (owner_rsp_ready) begin
          last_grant_next = owner_reg;
          state_next      = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      // Starting at 1 lets requester 0 win the first tie.
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      err_reg        <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      func_reg       <= '0;
      result_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      err_reg        <= err_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      func_reg       <= func_next;
      result_reg     <= result_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The ALU pins come only from the operand registers. Those registers change
  // only on an accepting edge, so the pins stay stable through ISSUE and RESP.
  assign alu_in1  = a_reg;
  assign alu_in2  = b_reg;
  assign alu_func = func_reg;

  assign busy = (state_reg != IDLE);

  assign rsp0_valid = (state_reg == RESP) && !owner_reg;
  assign rsp1_valid = (state_reg == RESP) &&  owner_reg;

  // Data and err read as zero whenever the matching valid is low.
  assign rsp0_data = rsp0_valid ? result_reg : '0;
  assign rsp1_data = rsp1_valid ? result_reg : '0;
  assign rsp0_err  = rsp0_valid && err_reg;
  assign rsp1_err  = rsp1_valid && err_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---- instance A: ALU_LAT = 1 ----
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0]  r0_func, r1_func;
  logic        s0_valid, s0_ready, s0_err, s1_valid, s1_ready, s1_err;
  logic [31:0] s0_data, s1_data;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_func;
  logic        busy;

  // ---- instance B: ALU_LAT = 3 ----
  logic        b_r0_valid, b_r0_ready, b_r1_valid, b_r1_ready;
  logic [31:0] b_r0_a, b_r0_b, b_r1_a, b_r1_b;
  logic [2:0]  b_r0_func, b_r1_func;
  logic        b_s0_valid, b_s0_ready, b_s0_err, b_s1_valid, b_s1_ready, b_s1_err;
  logic [31:0] b_s0_data, b_s1_data;
  logic [31:0] b_alu_in1, b_alu_in2, b_alu_out;
  logic [2:0]  b_alu_func;
  logic        b_busy;

  int errors = 0;
  int checks = 0;

  // Stand-in for the external ALU that the arbiter drives.
  function automatic logic [31:0] alu(input logic [31:0] x, input logic [31:0] y,
                                      input logic [2:0] f);
    logic [63:0] p;
    p = 64'(x) * 64'(y);
    case (f)
      3'b000:  return x + y;
      3'b001:  return x - y;
      3'b010:  return x & y;
      3'b011:  return x | y;
      3'b100:  return (x < y) ? 32'd1 : 32'd0;
      3'b101:  return p[31:0];
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out   = alu(alu_in1, alu_in2, alu_func);
  assign b_alu_out = alu(b_alu_in1, b_alu_in2, b_alu_func);

  alu_arbiter #(.ALU_LAT(1), .WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_a(r0_a), .req0_b(r0_b), .req0_func(r0_func),
    .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_a(r1_a), .req1_b(r1_b), .req1_func(r1_func),
    .rsp0_valid(s0_valid), .rsp0_ready(s0_ready), .rsp0_data(s0_data), .rsp0_err(s0_err),
    .rsp1_valid(s1_valid), .rsp1_ready(s1_ready), .rsp1_data(s1_data), .rsp1_err(s1_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_func(alu_func), .alu_out(alu_out),
    .busy(busy)
  );

  alu_arbiter #(.ALU_LAT(3), .WIDTH(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_r0_valid), .req0_ready(b_r0_ready), .req0_a(b_r0_a), .req0_b(b_r0_b), .req0_func(b_r0_func),
    .req1_valid(b_r1_valid), .req1_ready(b_r1_ready), .req1_a(b_r1_a), .req1_b(b_r1_b), .req1_func(b_r1_func),
    .rsp0_valid(b_s0_valid), .rsp0_ready(b_s0_ready), .rsp0_data(b_s0_data), .rsp0_err(b_s0_err),
    .rsp1_valid(b_s1_valid), .rsp1_ready(b_s1_ready), .rsp1_data(b_s1_data), .rsp1_err(b_s1_err),
    .alu_in1(b_alu_in1), .alu_in2(b_alu_in2), .alu_func(b_alu_func), .alu_out(b_alu_out),
    .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    r0_valid = 0; r0_a = 0; r0_b = 0; r0_func = 0; s0_ready = 0;
    r1_valid = 0; r1_a = 0; r1_b = 0; r1_func = 0; s1_ready = 0;
    b_r0_valid = 0; b_r0_a = 0; b_r0_b = 0; b_r0_func = 0; b_s0_ready = 0;
    b_r1_valid = 0; b_r1_a = 0; b_r1_b = 0; b_r1_func = 0; b_s1_ready = 0;

    // ---- reset state ----
    cycle();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp0_valid", 32'(s0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(s1_valid), 32'd0);
    check("rst_alu_in1", alu_in1, 32'd0);
    check("rst_alu_func", 32'(alu_func), 32'd0);
    r0_valid = 1;
    #1;
    check("rst_req0_ready_gated", 32'(r0_ready), 32'd0);
    r0_valid = 0;
    cycle();
    rst_n = 1'b1;
    #1;

    // ---- 1: single op ADD 5+7 ----
    r0_valid = 1; r0_a = 5; r0_b = 7; r0_func = 3'b000;
    #1;
    check("t1_req0_ready", 32'(r0_ready), 32'd1);
    check("t1_req1_ready", 32'(r1_ready), 32'd0);
    cycle();
    r0_valid = 0;
    check("t1_alu_in1", alu_in1, 32'd5);
    check("t1_alu_in2", alu_in2, 32'd7);
    check("t1_alu_func", 32'(alu_func), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_rsp0_early", 32'(s0_valid), 32'd0);
    cycle();
    check("t1_rsp0_valid", 32'(s0_valid), 32'd1);
    check("t1_rsp0_data", s0_data, 32'd12);
    check("t1_rsp0_err", 32'(s0_err), 32'd0);
    check("t1_rsp1_valid", 32'(s1_valid), 32'd0);
    s0_ready = 1;
    cycle();
    check("t1_busy_done", 32'(busy), 32'd0);
    check("t1_rsp0_data_zero", s0_data, 32'd0);
    $display("op1: req0 ADD 5,7 completed");

    // ---- 2: tie and round-robin ----
    do_reset();
    s0_ready = 1; s1_ready = 1;
    r0_valid = 1; r0_a = 10; r0_b = 3; r0_func = 3'b001;
    r1_valid = 1; r1_a = 6;  r1_b = 7; r1_func = 3'b101;
    #1;
    check("t2_tie_req0_ready", 32'(r0_ready), 32'd1);
    check("t2_tie_req1_ready", 32'(r1_ready), 32'd0);
    cycle();
    cycle();
    check("t2_rsp0_valid", 32'(s0_valid), 32'd1);
    check("t2_rsp0_data", s0_data, 32'd7);
    check("t2_resp_no_ready0", 32'(r0_ready), 32'd0);
    check("t2_resp_no_ready1", 32'(r1_ready), 32'd0);
    cycle();
    check("t2_rr_req1_ready", 32'(r1_ready), 32'd1);
    check("t2_rr_req0_ready", 32'(r0_ready), 32'd0);
    cycle();
    cycle();
    check("t2_rsp1_valid", 32'(s1_valid), 32'd1);
    check("t2_rsp1_data", s1_data, 32'd42);
    check("t2_rsp0_quiet", 32'(s0_valid), 32'd0);
    cycle();
    check("t2_third_req0_ready", 32'(r0_ready), 32'd1);
    check("t2_third_req1_ready", 32'(r1_ready), 32'd0);
    r0_valid = 0; r1_valid = 0;
    $display("op2: req0 SUB 10,3 then req1 MUL 6,7 completed");

    // ---- 3: response backpressure, req1 SLT 3<9 ----
    s1_ready = 0;
    r1_valid = 1; r1_a = 3; r1_b = 9; r1_func = 3'b100;
    #1;
    check("t3_req1_ready", 32'(r1_ready), 32'd1);
    cycle();
    r1_valid = 0;
    r0_valid = 1; r0_a = 4; r0_b = 5; r0_func = 3'b000;
    cycle();
    for (int i = 0; i < 5; i++) begin
      check("t3_rsp1_valid", 32'(s1_valid), 32'd1);
      check("t3_rsp1_data", s1_data, 32'd1);
      check("t3_req0_ready", 32'(r0_ready), 32'd0);
      check("t3_rsp0_valid", 32'(s0_valid), 32'd0);
      cycle();
    end
    s1_ready = 1;
    cycle();
    check("t3_busy_done", 32'(busy), 32'd0);
    $display("op3: req1 SLT 3,9 completed after backpressure");
    // req0 (ADD 4,5) waiting since RESP is granted now
    check("t3_req0_after", 32'(r0_ready), 32'd1);
    cycle();
    r0_valid = 0;
    cycle();
    check("t3_add_data", s0_data, 32'd9);
    cycle();
    $display("op4: req0 ADD 4,5 completed");

    // ---- 4: illegal func ----
    r0_valid = 1; r0_a = 1; r0_b = 1; r0_func = 3'b111;
    #1;
    check("t4_req0_ready", 32'(r0_ready), 32'd1);
    cycle();
    r0_valid = 0;
    check("t4_rsp0_valid", 32'(s0_valid), 32'd1);
    check("t4_rsp0_err", 32'(s0_err), 32'd1);
    check("t4_rsp0_data", s0_data, 32'd0);
    check("t4_alu_in1_kept", alu_in1, 32'd4);
    check("t4_alu_in2_kept", alu_in2, 32'd5);
    check("t4_alu_func_kept", 32'(alu_func), 32'd0);
    cycle();
    check("t4_busy_done", 32'(busy), 32'd0);
    $display("op5: req0 illegal func 111 returned err");

    // ---- 5: ALU_LAT=3, OR 0xF0|0x0F ----
    b_s0_ready = 1;
    b_r0_valid = 1; b_r0_a = 32'hF0; b_r0_b = 32'h0F; b_r0_func = 3'b011;
    #1;
    check("t5_req0_ready", 32'(b_r0_ready), 32'd1);
    cycle();
    b_r0_valid = 0;
    for (int k = 0; k < 3; k++) begin
      check("t5_rsp0_early", 32'(b_s0_valid), 32'd0);
      check("t5_alu_in1", b_alu_in1, 32'hF0);
      check("t5_alu_in2", b_alu_in2, 32'h0F);
      check("t5_alu_func", 32'(b_alu_func), 32'd3);
      cycle();
    end
    check("t5_rsp0_valid", 32'(b_s0_valid), 32'd1);
    check("t5_rsp0_data", b_s0_data, 32'hFF);
    cycle();
    check("t5_busy_done", 32'(b_busy), 32'd0);
    $display("op6: lat3 req0 OR 0xF0,0x0F completed");

    // ---- 6: reset mid-ISSUE ----
    s0_ready = 0;
    r0_valid = 1; r0_a = 2; r0_b = 3; r0_func = 3'b000;
    #1;
    // last grant was req0, so make req0 the lone requester
    check("t6_req0_ready", 32'(r0_ready), 32'd1);
    cycle();
    r0_valid = 0;
    check("t6_busy_issue", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_rsp0", 32'(s0_valid), 32'd0);
    check("t6_rst_alu_in1", alu_in1, 32'd0);
    check("t6_rst_alu_in2", alu_in2, 32'd0);
    cycle();
    rst_n = 1'b1;
    #1;
    cycle();
    check("t6_no_resp", 32'(s0_valid), 32'd0);
    r0_valid = 1; r1_valid = 1;
    #1;
    check("t6_tie_req0", 32'(r0_ready), 32'd1);
    check("t6_tie_req1", 32'(r1_ready), 32'd0);
    r0_valid = 0; r1_valid = 0;
    $display("op7: reset mid-issue aborted operation");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
